path_reader: RTL and testbench
==============================

# path_reader

Drains the location stack once the maze search has finished and replays the stored path from start cell to goal cell. It is the consumer end of the stack's push/pop interface: it drives `pop`, captures each popped 8-bit location (X in [7:4], Y in [3:0]) into a local buffer, then streams the locations out in reverse pop order (original push order) over a valid/ready handshake. It sits between the stack and the path display/output logic.

## Interface
- DEPTH, 64: path buffer entries; must cover the stack's 63-entry maximum.
- CW, 7: width of `count`, ceil(log2(DEPTH+1)).
- clk  input  1  rising-edge clock shared with the stack.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request to drain and replay; ignored unless idle.
- empStck  input  1  stack empty flag.
- locIn  input  8  stack's `locOut`.
- pop  output  1  pop request to the stack; registered.
- outLoc  output  8  replayed location.
- outValid  output  1  `outLoc` is valid.
- outReady  input  1  downstream accepts `outLoc`.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of a run.
- err  output  1  overflow flag; sticky until next accepted `start` or reset.
- count  output  CW  entries captured in the current or last run.

## Operation
- Buffer: DEPTH x 8 registers. Write pointer `wr`, read index `rd`.
- FSM states: IDLE, POP, CAPTURE, EMIT, DONE.
- IDLE:
  - On `start`: clear `wr`, `count`, `err`.
  - If `empStck` = 1, go to DONE. Otherwise go to POP.
- POP: `pop` = 1 for exactly this cycle, then go to CAPTURE.
- CAPTURE:
  - Write `buf[wr]` <= `locIn`; increment `wr` and `count`.
  - If `empStck` = 1: set `rd` <= `wr` (the old value, i.e. the last written index) and go to EMIT.
  - Else if `wr`+1 = DEPTH: set `err` = 1 and go to DONE. There is no emission and no further pop.
  - Otherwise go back to POP.
- EMIT:
  - `outValid` = 1 and `outLoc` = `buf[rd]`.
  - On `outValid` & `outReady`: if `rd` = 0, go to DONE; else decrement `rd`.
  - `outLoc` stays stable while `outValid` = 1 and `outReady` = 0.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `pop` is never asserted while `empStck` = 1 was sampled in the preceding decision cycle, so the block never pops an empty stack.
- `start` outside IDLE has no effect.
- `count` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE; `pop`, `outValid`, `busy`, `done`, `err` = 0; `outLoc` = 8'h00; `count` = 0; `wr` = `rd` = 0.
- Buffer contents do not need to be reset.
- Reset takes effect asynchronously. A reset in any state, including mid-POP, deasserts `pop` and `outValid` immediately, with no completion pulse.
- The stack updates `locOut` and its pointer on the edge that ends the POP cycle. `locIn` and `empStck` are therefore valid during CAPTURE.
- Drain rate: 2 cycles per entry.
  - N entries: `start` at edge 0, POP in cycles 1,3,…,2N-1, last CAPTURE in cycle 2N, first `outValid` in cycle 2N+1.
- Emit rate: 1 entry per cycle when `outReady` = 1.
  - `done` comes in the cycle after the last handshake.
- Empty stack at `start`: DONE in cycle 1, `done` high for that cycle, then IDLE in cycle 2.

## Test plan
- Reset: hold `rst` = 0 with `start` = 1 and `outReady` = 1 -> all outputs at reset values. Release, no `start` -> `pop` stays 0.
- Three-entry path: stack pushed with 8'h00, 8'h12, 8'h23; `start` with `outReady` = 1 -> three single-cycle `pop` pulses 2 cycles apart; `outLoc` = 00, 12, 23 on consecutive cycles; `count` = 3; one `done` pulse; `err` = 0; stack empty afterwards.
- Empty stack: `start` with `empStck` = 1 -> no `pop`, no `outValid`, `done` one cycle later, `count` = 0.
- Backpressure: 2-entry path, hold `outReady` = 0 for 5 cycles during EMIT -> `outValid` stays 1 and `outLoc` stays at the first location. Raise `outReady` -> remaining location follows, then `done`.
- Overflow: DEPTH = 4, stack holding 6 entries -> exactly 4 pops, `err` = 1, no `outValid`, `done` pulse, `count` = 4. The next `start` clears `err`.
- Reset mid-run: assert `rst` = 0 during the 2nd EMIT handshake -> `outValid` and `busy` drop immediately with no `done`. Restart on an empty stack -> normal empty-run behaviour.

Source files
------------

// File: rtl/path_reader.sv
// Path reader: drains the location stack after the search and replays the path in push order.
// Latency: 2 cycles per captured entry, first outValid in cycle 2N+1 after start, then 1 entry/cycle.
// Backpressure: outLoc/outValid hold while outReady is low; the stack is never popped while empty.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-low reset
//   start         - one-cycle run request, honoured only in IDLE
//   empStck/locIn - stack empty flag and popped location (X in [7:4], Y in [3:0])
//   pop           - registered pop request to the stack
//   outLoc/outValid/outReady - replay stream (valid/ready)
//   busy/done/err/count      - run status; err is sticky until the next accepted start
module path_reader #(
    parameter int DEPTH = 64,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          empStck,
    input  logic [7:0]    locIn,
    output logic          pop,
    output logic [7:0]    outLoc,
    output logic          outValid,
    input  logic          outReady,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            r_err;
    logic            r_pop;
    logic [7:0]      r_buf [DEPTH];
    logic            w_hs;
    logic            w_last_slot;

    assign w_hs        = (r_state == S_EMIT) && outReady;
    // The slot being written now is the final one; another pop would have nowhere to land.
    assign w_last_slot = ((CW'(r_wr) + CW'(1)) == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = empStck ? S_DONE : S_POP;
                end
            end
            S_POP: begin
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Empty check wins, so a stack of exactly DEPTH entries still replays.
                if (empStck) begin
                    w_next = S_EMIT;
                end else if (w_last_slot) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_POP;
                end
            end
            S_EMIT: begin
                if (w_hs && (r_rd == '0)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_pop   <= 1'b0;
        end else begin
            // pop is registered off the next state so it is high for exactly the POP cycle.
            r_pop <= (w_next == S_POP);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wr    <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    r_wr    <= r_wr + AW'(1);
                    r_count <= r_count + CW'(1);
                    if (empStck) begin
                        r_rd <= r_wr;
                    end else if (w_last_slot) begin
                        r_err <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_hs && (r_rd != '0)) begin
                        r_rd <= r_rd - AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Path storage carries no reset: every entry read in EMIT was written in the same run.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            r_buf[r_wr] <= locIn;
        end
    end

    assign pop      = r_pop;
    assign outValid = (r_state == S_EMIT);
    assign outLoc   = (r_state == S_EMIT) ? r_buf[r_rd] : 8'h00;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
    assign count    = r_count;

endmodule

// File: tb/tb_path_reader.sv
module tb_path_reader;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          outReady = 1'b0;
    logic          empStck;
    logic [7:0]    locIn;
    logic          pop;
    logic [7:0]    outLoc;
    logic          outValid;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] count;

    path_reader #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .empStck  (empStck),
        .locIn    (locIn),
        .pop      (pop),
        .outLoc   (outLoc),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Stack model: locOut and pointer update on the edge that ends the POP cycle.
    logic [7:0] stk [16];
    int         sp        = 0;
    int         pop_empty = 0;
    logic [7:0] loc_r     = 8'h00;
    logic       push      = 1'b0;
    logic       clr       = 1'b0;
    logic [7:0] push_dat  = 8'h00;

    always @(posedge clk) begin
        if (clr) begin
            sp <= 0;
        end else if (push) begin
            stk[sp] <= push_dat;
            sp      <= sp + 1;
        end else if (pop) begin
            if (sp == 0) begin
                pop_empty <= pop_empty + 1;
            end else begin
                loc_r <= stk[sp-1];
                sp    <= sp - 1;
            end
        end
    end

    assign empStck = (sp == 0);
    assign locIn   = loc_r;

    // Cycle counter and event monitor.
    int         cyc = 0;
    int         pop_q [$];
    logic [7:0] hs_q [$];
    int         hs_cyc [$];
    int         n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pop) pop_q.push_back(cyc);
        if (outValid && outReady) begin
            hs_q.push_back(outLoc);
            hs_cyc.push_back(cyc);
        end
        if (done) n_done <= n_done + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_stack(input logic [7:0] d);
        @(posedge clk); #1;
        push     = 1'b1;
        push_dat = d;
        @(posedge clk); #1;
        push     = 1'b0;
    endtask

    task automatic clear_stack();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Returns the number of the edge that samples start; relative cycle = cyc - t0 + 1.
    task automatic do_start(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t0, output int rel);
        bit seen = 0;
        int i    = 0;
        rel = -1;
        #1;
        while (!seen && i < 80) begin
            if (done) begin
                seen = 1;
                rel  = cyc - t0 + 1;
            end else begin
                @(posedge clk); #2;
                i++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int t0, rel, pb, hb, nd, k;
        bit seen;

        // Reset held with start and outReady high.
        start    = 1'b1;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_pop",      32'(pop),      32'd0);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_outLoc",   32'(outLoc),   32'h00);
        check("rst_count",    32'(count),    32'd0);
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        pb = pop_q.size();
        repeat (5) @(posedge clk);
        #2;
        check("idle_no_pop", 32'(pop_q.size() - pb), 32'd0);

        // Three-entry path.
        push_stack(8'h00);
        push_stack(8'h12);
        push_stack(8'h23);
        pb = pop_q.size(); hb = hs_q.size(); nd = n_done;
        outReady = 1'b1;
        do_start(t0);
        wait_done("three", t0, rel);
        check("three_done_cycle", 32'(rel), 32'd10);
        check("three_pops",       32'(pop_q.size() - pb), 32'd3);
        check("three_pop1_cycle", 32'(pop_q[pb]   - t0 + 1), 32'd1);
        check("three_pop2_cycle", 32'(pop_q[pb+1] - t0 + 1), 32'd3);
        check("three_pop3_cycle", 32'(pop_q[pb+2] - t0 + 1), 32'd5);
        check("three_hs_num",     32'(hs_q.size() - hb), 32'd3);
        check("three_loc0",       32'(hs_q[hb]),   32'h00);
        check("three_loc1",       32'(hs_q[hb+1]), 32'h12);
        check("three_loc2",       32'(hs_q[hb+2]), 32'h23);
        check("three_first_valid", 32'(hs_cyc[hb] - t0 + 1), 32'd7);
        check("three_hs_span",    32'(hs_cyc[hb+2] - hs_cyc[hb]), 32'd2);
        check("three_count",      32'(count), 32'd3);
        check("three_err",        32'(err),   32'd0);
        check("three_stack_empty", 32'(sp),   32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("three_done_pulses", 32'(n_done - nd), 32'd1);
        check("three_idle_busy",   32'(busy), 32'd0);

        // Empty stack at start.
        pb = pop_q.size(); hb = hs_q.size();
        do_start(t0);
        wait_done("empty", t0, rel);
        check("empty_done_cycle", 32'(rel), 32'd1);
        check("empty_count",      32'(count), 32'd0);
        @(posedge clk); #2;
        check("empty_idle_busy",  32'(busy), 32'd0);
        check("empty_pops",       32'(pop_q.size() - pb), 32'd0);
        check("empty_valids",     32'(hs_q.size() - hb), 32'd0);

        // Backpressure during EMIT.
        push_stack(8'h34);
        push_stack(8'h45);
        hb = hs_q.size();
        outReady = 1'b0;
        do_start(t0);
        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #2;
            if (outValid) seen = 1;
            k++;
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        for (int j = 0; j < 5; j++) begin
            check("bp_hold_valid", 32'(outValid), 32'd1);
            check("bp_hold_loc",   32'(outLoc),   32'h34);
            @(posedge clk); #2;
        end
        outReady = 1'b1;
        wait_done("bp", t0, rel);
        check("bp_hs_num", 32'(hs_q.size() - hb), 32'd2);
        check("bp_loc0",   32'(hs_q[hb]),   32'h34);
        check("bp_loc1",   32'(hs_q[hb+1]), 32'h45);
        check("bp_count",  32'(count), 32'd2);

        // Overflow: six entries into a four-deep buffer.
        for (int j = 1; j <= 6; j++) push_stack(8'h50 + 8'(j));
        pb = pop_q.size(); hb = hs_q.size(); nd = n_done;
        do_start(t0);
        wait_done("ovf", t0, rel);
        check("ovf_done_cycle", 32'(rel), 32'd9);
        check("ovf_err",        32'(err),   32'd1);
        check("ovf_count",      32'(count), 32'd4);
        check("ovf_stack_left", 32'(sp),    32'd2);
        repeat (2) @(posedge clk);
        #2;
        check("ovf_pops",        32'(pop_q.size() - pb), 32'd4);
        check("ovf_valids",      32'(hs_q.size() - hb),  32'd0);
        check("ovf_done_pulses", 32'(n_done - nd),       32'd1);
        check("ovf_err_sticky",  32'(err), 32'd1);
        hb = hs_q.size();
        do_start(t0);
        #1;
        check("ovf_err_cleared", 32'(err), 32'd0);
        wait_done("ovf_rerun", t0, rel);
        check("ovf_rerun_hs",    32'(hs_q.size() - hb), 32'd2);
        check("ovf_rerun_loc0",  32'(hs_q[hb]),   32'h51);
        check("ovf_rerun_loc1",  32'(hs_q[hb+1]), 32'h52);
        check("ovf_rerun_count", 32'(count), 32'd2);

        // Reset during the second EMIT handshake.
        push_stack(8'h61);
        push_stack(8'h62);
        push_stack(8'h63);
        hb = hs_q.size();
        do_start(t0);
        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #2;
            if (hs_q.size() == hb + 1) seen = 1;
            k++;
        end
        check("mid_first_hs_seen", 32'(seen), 32'd1);
        check("mid_second_valid",  32'(outValid), 32'd1);
        nd = n_done;
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid",  32'(outValid), 32'd0);
        check("mid_rst_busy",   32'(busy),     32'd0);
        check("mid_rst_pop",    32'(pop),      32'd0);
        check("mid_rst_outLoc", 32'(outLoc),   32'h00);
        clear_stack();
        repeat (2) @(posedge clk);
        #2;
        check("mid_rst_no_done", 32'(n_done - nd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pb = pop_q.size(); hb = hs_q.size();
        do_start(t0);
        wait_done("mid_restart", t0, rel);
        check("mid_restart_cycle",  32'(rel),   32'd1);
        check("mid_restart_count",  32'(count), 32'd0);
        @(posedge clk); #2;
        check("mid_restart_pops",   32'(pop_q.size() - pb), 32'd0);
        check("mid_restart_valids", 32'(hs_q.size() - hb),  32'd0);
        check("never_pop_empty",    32'(pop_empty), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
